// File: rtl/mac_accumulator.sv
// Multiply-accumulate cell for a systolic array: sums K unsigned products per result
// and forwards its operands to the neighbouring cell with one cycle of delay.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | no terms accepted yet, acc = 0
// ACCUM  | 1..K-1 terms accepted, waiting for more
// DONE   | K terms summed, result held until the consumer takes it
module mac_accumulator #(
    parameter int K     = 7,
    parameter int DW    = 8,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    a_in,
    input  logic [DW-1:0]    b_in,
    output logic [DW-1:0]    a_out,
    output logic [DW-1:0]    b_out,
    output logic             valid_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             busy
);

    localparam int CNT_W = $clog2(K + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     a_out_q, a_out_d;
    logic [DW-1:0]     b_out_q, b_out_d;
    logic              valid_out_q, valid_out_d;
    logic [2*DW-1:0]   prod;
    logic              accept;

    assign prod   = a_in * b_in;
    assign accept = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        a_out_d     = a_in;
        b_out_d     = b_in;
        valid_out_d = in_valid;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = ACC_W'(prod);
                    cnt_d   = CNT_W'(1);
                    state_d = (K == 1) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    acc_d = acc_q + ACC_W'(prod);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(K - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // Abort wins over every other event, including a term presented this cycle.
        if (clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            a_out_q     <= '0;
            b_out_q     <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Status outputs decode straight from flops so reset clears them without a clock.
    assign in_ready  = (state_q != S_DONE);
    assign res_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign res_data  = acc_q;
    assign a_out     = a_out_q;
    assign b_out     = b_out_q;
    assign valid_out = valid_out_q;

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter K, default 7, meaning the number of products summed per result (one per byte of a 56-bit feeder burst).
REQ-002 SHALL have parameter DW, default 8, meaning the operand width.
REQ-003 SHALL have parameter ACC_W, default 20, meaning the accumulator and result width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port clear, input, 1, synchronous abort and restart of the current dot product.
REQ-007 SHALL have port in_valid, input, 1, meaning a_in/b_in carry a term.
REQ-008 SHALL have port in_ready, output, 1, meaning a term is accepted this cycle.
REQ-009 SHALL have port a_in, input, DW, the row operand byte from the upstream feeder.
REQ-010 SHALL have port b_in, input, DW, the column operand byte from the upstream feeder.
REQ-011 SHALL have port a_out, output, DW, a_in registered for the systolic neighbour.
REQ-012 SHALL have port b_out, output, DW, b_in registered for the systolic neighbour.
REQ-013 SHALL have port valid_out, output, 1, in_valid registered for the neighbour.
REQ-014 SHALL have port res_valid, output, 1, meaning a result is presented.
REQ-015 SHALL have port res_ready, input, 1, meaning the consumer takes the result.
REQ-016 SHALL have port res_data, output, ACC_W, the dot-product result.
REQ-017 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-018 SHALL register a_out<=a_in, b_out<=b_in and valid_out<=in_valid on every clock, independent of FSM state, giving 1-cycle passthrough latency.
REQ-019 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-020 SHALL drive in_ready = (state != DONE); a term is accepted only when in_valid and in_ready are both high.
REQ-021 SHALL, in IDLE on an accepted term, load acc=a_in*b_in and cnt=1, then go to ACCUM, or to DONE if K==1.
REQ-022 SHALL, in ACCUM on an accepted term, set acc=acc+a_in*b_in and cnt=cnt+1, going to DONE when the K-th term is accepted.
REQ-023 SHALL hold acc and cnt in IDLE and ACCUM on cycles where in_valid is low, so gaps between terms are allowed.
REQ-024 SHALL treat arithmetic as unsigned, with a 2*DW-bit product zero-extended to ACC_W and no saturation; ACC_W >= 2*DW+ceil(log2 K) is a parameter-legality rule.
REQ-025 SHALL, in DONE, drive res_valid=1 with res_data=acc, both held stable until the handshake completes.
REQ-026 SHALL ignore in_valid in DONE (in_ready=0) and make no change to acc.
REQ-027 SHALL, on res_valid & res_ready, go to IDLE next cycle with acc=0, cnt=0, res_valid=0.
REQ-028 SHALL give the result latency as res_valid high on the cycle after the edge accepting the K-th term.
REQ-029 SHALL let clear (sync) override all other events in any state: next state IDLE, acc=0, cnt=0, res_valid=0, and any term presented with clear is dropped.
REQ-030 SHALL drive res_data=acc in every state.

Reset
REQ-031 SHALL, on reset assertion and without waiting for a clock, force state=IDLE, acc=0, cnt=0, res_valid=0, res_data=0, busy=0, a_out=0, b_out=0, valid_out=0 and in_ready=1.
REQ-032 SHALL abort any in-progress or pending result on reset, with no output after deassertion until K new terms are accepted.

Verification
REQ-033 SHALL cover: a bytes 11,22,33,44,55,66,77, b=01 each, back-to-back -> res_valid 1 cycle after 7th term, res_data=0x1DC.
REQ-034 SHALL cover: a=b=FF for 7 terms with idle gaps of 0-3 cycles between terms -> res_data=0x6F207, no overflow.
REQ-035 SHALL cover: res_ready low 5 cycles in DONE with in_valid toggling -> res_valid/res_data stable, in_ready=0, then next result excludes the ignored terms.
REQ-036 SHALL cover: clear after 3 terms of FF*FF, then 7 terms a=02 b=03 -> res_data=0x2A.
REQ-037 SHALL cover: reset asserted between clock edges while in DONE -> res_valid, res_data and busy go 0 immediately.
REQ-038 SHALL cover: random a_in/b_in/in_valid -> a_out/b_out/valid_out equal the inputs delayed exactly 1 cycle in all states.
